// File: rtl/svreal_reg_alu_pkg.sv
// Shared types for the registered svreal ALU: exponent type, opcode encoding
// and the exponent-max helper used by the comparison path.
package svreal_alu_pkg;

    typedef logic signed [31:0] svreal_alu_exp_t;

    typedef enum logic [3:0] {
        OP_MUL = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_NEG = 4'd3,
        OP_MIN = 4'd4,
        OP_MAX = 4'd5,
        OP_GT  = 4'd8,
        OP_GE  = 4'd9,
        OP_LT  = 4'd10,
        OP_LE  = 4'd11,
        OP_EQ  = 4'd12,
        OP_NE  = 4'd13
    } svreal_alu_op_t;

    function automatic svreal_alu_exp_t max_exp(input svreal_alu_exp_t x,
                                                input svreal_alu_exp_t y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/svreal_align.sv
// Combinational re-scaling of a signed mantissa from in_exponent to out_exponent.
// Wraps to OUT_WIDTH by default; saturates when SVREAL_SAT_EN is defined.
module svreal_align
    import svreal_alu_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16
) (
    input  logic [IN_WIDTH-1:0]  in_value,
    input  logic [31:0]          in_exponent,
    input  logic [31:0]          out_exponent,
    output logic [OUT_WIDTH-1:0] out_value
);

    // Wide enough that any shift below 64 keeps every bit and the sign.
    localparam int WIDE = ((IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH) + 64;

    logic signed [32:0]     sh;
    logic signed [WIDE-1:0] x_wide;
    logic signed [WIDE-1:0] shifted;
    logic [5:0]             amt_r;
    logic                   neg;
    logic                   big_left;

    always_comb begin
        sh       = {in_exponent[31], in_exponent} - {out_exponent[31], out_exponent};
        x_wide   = WIDE'($signed(in_value));
        neg      = in_value[IN_WIDTH-1];
        amt_r    = 6'd0 - sh[5:0];
        big_left = 1'b0;
        if (sh >= 33'sd64) begin
            big_left = 1'b1;
            shifted  = '0;
        end else if (sh <= -33'sd64) begin
            shifted  = {WIDE{neg}};
        end else if (sh >= 33'sd0) begin
            shifted  = x_wide <<< sh[5:0];
        end else begin
            shifted  = x_wide >>> amt_r;
        end
    end

`ifdef SVREAL_SAT_EN
    logic fits;
    logic ovf;
    always_comb begin
        fits = (&shifted[WIDE-1:OUT_WIDTH-1]) | ~(|shifted[WIDE-1:OUT_WIDTH-1]);
        ovf  = (big_left && (in_value != '0)) || !fits;
        if (ovf)
            out_value = neg ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else
            out_value = shifted[OUT_WIDTH-1:0];
    end
`else
    logic unused_hi;
    assign unused_hi = ^{shifted[WIDE-1:OUT_WIDTH], big_left};
    assign out_value = shifted[OUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/svreal_reg_alu.sv
// Registered svreal arithmetic/compare unit, one cycle latency, no backpressure.
// Optional build macro SVREAL_SAT_EN: saturate writes to c_value instead of wrapping.
module svreal_reg_alu
    import svreal_alu_pkg::*;
#(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 16,
    parameter int C_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [3:0]         opcode,
    input  logic [A_WIDTH-1:0] a_value,
    input  logic [31:0]        a_exponent,
    input  logic [B_WIDTH-1:0] b_value,
    input  logic [31:0]        b_exponent,
    input  logic [31:0]        c_exponent,
    output logic               out_valid,
    output logic [C_WIDTH-1:0] c_value,
    output logic               c_flag,
    output logic               out_err
);

    // Handshake: a request is accepted on every edge where in_valid=1 (no ready);
    // out_valid pulses for exactly the cycle after that edge.
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int CMP_W   = (A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH;

    svreal_alu_op_t         op;
    logic signed [A_WIDTH:0] a_ext;
    logic signed [A_WIDTH:0] a_src;
    logic signed [P_WIDTH-1:0] prod;
    svreal_alu_exp_t        prod_exp;
    svreal_alu_exp_t        cmp_exp;
    logic [C_WIDTH-1:0]     a_al, b_al, p_al;
    logic [A_WIDTH-1:0]     a_cmp;
    logic [B_WIDTH-1:0]     b_cmp;
    logic signed [CMP_W-1:0] ac, bc;
    logic [C_WIDTH-1:0]     sum_c, diff_c;
    logic [C_WIDTH-1:0]     nxt_value;
    logic                   nxt_flag, nxt_err;

    assign op       = svreal_alu_op_t'(opcode);
    assign a_ext    = {a_value[A_WIDTH-1], a_value};
    // NEG negates before alignment so rounding applies to -a and the extra bit absorbs -min.
    assign a_src    = (op == OP_NEG) ? -a_ext : a_ext;
    assign prod     = P_WIDTH'($signed(a_value)) * P_WIDTH'($signed(b_value));
    assign prod_exp = $signed(a_exponent) + $signed(b_exponent);
    assign cmp_exp  = max_exp($signed(a_exponent), $signed(b_exponent));

    svreal_align #(.IN_WIDTH(A_WIDTH+1), .OUT_WIDTH(C_WIDTH)) u_align_a (
        .in_value(a_src), .in_exponent(a_exponent), .out_exponent(c_exponent), .out_value(a_al));
    svreal_align #(.IN_WIDTH(B_WIDTH), .OUT_WIDTH(C_WIDTH)) u_align_b (
        .in_value(b_value), .in_exponent(b_exponent), .out_exponent(c_exponent), .out_value(b_al));
    svreal_align #(.IN_WIDTH(P_WIDTH), .OUT_WIDTH(C_WIDTH)) u_align_p (
        .in_value(prod), .in_exponent(prod_exp), .out_exponent(c_exponent), .out_value(p_al));
    svreal_align #(.IN_WIDTH(A_WIDTH), .OUT_WIDTH(A_WIDTH)) u_cmp_a (
        .in_value(a_value), .in_exponent(a_exponent), .out_exponent(cmp_exp), .out_value(a_cmp));
    svreal_align #(.IN_WIDTH(B_WIDTH), .OUT_WIDTH(B_WIDTH)) u_cmp_b (
        .in_value(b_value), .in_exponent(b_exponent), .out_exponent(cmp_exp), .out_value(b_cmp));

    assign ac = CMP_W'($signed(a_cmp));
    assign bc = CMP_W'($signed(b_cmp));

`ifdef SVREAL_SAT_EN
    logic signed [C_WIDTH:0] sum_w, diff_w;
    localparam logic [C_WIDTH-1:0] C_MIN = {1'b1, {(C_WIDTH-1){1'b0}}};
    localparam logic [C_WIDTH-1:0] C_MAX = {1'b0, {(C_WIDTH-1){1'b1}}};
    assign sum_w  = {a_al[C_WIDTH-1], a_al} + {b_al[C_WIDTH-1], b_al};
    assign diff_w = {a_al[C_WIDTH-1], a_al} - {b_al[C_WIDTH-1], b_al};
    assign sum_c  = (sum_w[C_WIDTH] != sum_w[C_WIDTH-1])
                  ? (sum_w[C_WIDTH] ? C_MIN : C_MAX) : sum_w[C_WIDTH-1:0];
    assign diff_c = (diff_w[C_WIDTH] != diff_w[C_WIDTH-1])
                  ? (diff_w[C_WIDTH] ? C_MIN : C_MAX) : diff_w[C_WIDTH-1:0];
`else
    assign sum_c  = a_al + b_al;
    assign diff_c = a_al - b_al;
`endif

    always_comb begin
        nxt_value = c_value;
        nxt_flag  = c_flag;
        nxt_err   = 1'b0;
        case (op)
            OP_MUL: nxt_value = p_al;
            OP_ADD: nxt_value = sum_c;
            OP_SUB: nxt_value = diff_c;
            OP_NEG: nxt_value = a_al;
            OP_MIN: nxt_value = (bc < ac) ? b_al : a_al;
            OP_MAX: nxt_value = (bc > ac) ? b_al : a_al;
            OP_GT:  nxt_flag  = ac >  bc;
            OP_GE:  nxt_flag  = ac >= bc;
            OP_LT:  nxt_flag  = ac <  bc;
            OP_LE:  nxt_flag  = ac <= bc;
            OP_EQ:  nxt_flag  = ac == bc;
            OP_NE:  nxt_flag  = ac != bc;
            default: begin
                nxt_value = '0;
                nxt_flag  = 1'b0;
                nxt_err   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            c_value   <= '0;
            c_flag    <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c_value <= nxt_value;
                c_flag  <= nxt_flag;
                out_err <= nxt_err;
            end
        end
    end

endmodule

// File: tb/tb_svreal_reg_alu.sv
// Directed-vector bench for svreal_reg_alu with an expected-response queue
// drained by an independent output monitor.
module tb_svreal_reg_alu;

    localparam int AW = 16;
    localparam int BW = 16;
    localparam int CW = 16;
    localparam int W  = CW + 2;

`ifdef SVREAL_SAT_EN
    localparam int OVF_ADD = 32767;
    localparam int OVF_NEG = 32767;
    localparam int OVF_BIG = 32767;
`else
    localparam int OVF_ADD = -32768;
    localparam int OVF_NEG = -32768;
    localparam int OVF_BIG = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [3:0]    opcode = '0;
    logic [AW-1:0] a_value = '0;
    logic [31:0]   a_exponent = '0;
    logic [BW-1:0] b_value = '0;
    logic [31:0]   b_exponent = '0;
    logic [31:0]   c_exponent = '0;
    logic          out_valid;
    logic [CW-1:0] c_value;
    logic          c_flag;
    logic          out_err;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    svreal_reg_alu #(.A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
        .a_value(a_value), .a_exponent(a_exponent),
        .b_value(b_value), .b_exponent(b_exponent), .c_exponent(c_exponent),
        .out_valid(out_valid), .c_value(c_value), .c_flag(c_flag), .out_err(out_err));

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // driver: one request per call; the expected response is queued at issue time
    task automatic issue(input string name, input int op, input int av, input int ae,
                         input int bv, input int be, input int ce,
                         input int ev, input int ef, input int ee);
        opcode     = 4'(op);
        a_value    = AW'(av);
        a_exponent = ae;
        b_value    = BW'(bv);
        b_exponent = be;
        c_exponent = ce;
        in_valid   = 1'b1;
        exp_q.push_back({1'(ee), 1'(ef), CW'(ev)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (name.len() == 0) $display("unnamed vector");
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("c_value", int'($signed(c_value)), int'($signed(e[CW-1:0])));
                check("c_flag", int'(c_flag), int'(e[CW]));
                check("out_err", int'(out_err), int'(e[CW+1]));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_c_value", int'(c_value), 0);
        check("reset_c_flag", int'(c_flag), 0);
        check("reset_out_err", int'(out_err), 0);

        //     name     op  a     ae  b    be   ce   val      flag err
        issue("add",    1,  384,  -8, 256, -10, -8,  448,     0, 0);
        issue("sub",    2,  384,  -8, 256, -10, -8,  320,     0, 0);
        issue("mul",    0,  384,  -8, 256, -10, -8,  96,      0, 0);
        issue("gt",     8,  384,  -8, 256, -10, -8,  96,      1, 0);
        issue("eq",     12, 384,  -8, 256, -10, -8,  96,      0, 0);
        issue("min",    4,  384,  -8, 256, -10, -8,  64,      0, 0);
        issue("max",    5,  384,  -8, 256, -10, -8,  384,     0, 0);
        issue("min_neg",4, -256,  -8, 256, -10, -8, -256,     0, 0);
        issue("lt_neg", 10,-256,  -8, 256, -10, -8, -256,     1, 0);
        issue("eq_same",12, 64,   -8, 256, -10, -8, -256,     1, 0);
        issue("ge_same",9,  64,   -8, 256, -10, -8, -256,     1, 0);
        issue("ne_same",13, 64,   -8, 256, -10, -8, -256,     0, 0);
        issue("le_gt",  11, 384,  -8, 256, -10, -8, -256,     0, 0);
        issue("gt_same",8,  64,   -8, 256, -10, -8, -256,     0, 0);
        issue("neg_rnd",3,  3,    0,  0,   0,   1,  -2,       0, 0);
        issue("big_rsh",1, -5,    0,  0,   0,   100, -1,      0, 0);
        issue("add_ovf",1,  32767,0,  1,   0,   0,  OVF_ADD,  0, 0);
        issue("neg_min",3, -32768,0,  0,   0,   0,  OVF_NEG,  0, 0);
        issue("big_lsh",1,  1,    100,0,   0,   0,  OVF_BIG,  0, 0);
        issue("bad_op7",7,  5,    0,  5,   0,   0,  0,        0, 1);
        issue("add_clr",1,  1,    0,  2,   0,   0,  3,        0, 0);
        issue("ge_hold",9,  384,  -8, 256, -10, -8, 3,        1, 0);
        issue("bad_op15",15,5,    0,  5,   0,   0,  0,        0, 1);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        // reset mid-operation: a request presented during reset is dropped
        opcode   = 4'd1;
        a_value  = AW'(100);
        b_value  = BW'(7);
        in_valid = 1'b1;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_c_value", int'(c_value), 0);
        check("midrst_c_flag", int'(c_flag), 0);
        check("midrst_out_err", int'(out_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
